// File: rtl/gpu_prog_ctrl.sv
// gpu_prog_ctrl: streams a host program into instruction memory while the
// GPU is held in reset, then releases the GPU and watches for HALT or a
// watchdog expiry before putting it back into reset.
module gpu_prog_ctrl #(
    parameter int          ADDR_W  = 7,
    parameter int          DEPTH   = 128,
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_start,
    input  logic              abort,
    input  logic              gpu_halted,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              gpu_rst,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [ADDR_W:0]   prog_len,
    output logic [31:0]       run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] wr_ptr;
    logic            first_run;
    logic            accept;
    logic            load_end;
    logic            wd_expired;
    logic            enter_load;
    logic            enter_run;

    // load_ready, busy, done and gpu_rst all come straight from the state register
    assign load_ready = (state == S_LOAD);
    assign busy       = (state == S_LOAD) || (state == S_RUN);
    assign done       = (state == S_DONE);
    assign gpu_rst    = (state != S_RUN);

    // a word is accepted unless a restart or abort in the same cycle discards it
    assign accept     = load_ready && load_valid && !load_start && !abort;
    assign load_end   = accept && (load_last || (wr_ptr == LAST_ADDR));
    assign wd_expired = (run_cycles == TIMEOUT);
    assign enter_load = !abort && load_start && (state != S_RUN);
    assign enter_run  = (state != S_RUN) && (state_nxt == S_RUN);

    // next-state selection; abort beats load_start beats run_start beats halt/watchdog
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (load_start)    state_nxt = S_LOAD;
                    else if (load_end) state_nxt = S_READY;
                end
                S_READY, S_DONE: begin
                    if (load_start)     state_nxt = S_LOAD;
                    else if (run_start) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (wd_expired)                     state_nxt = S_DONE;
                    else if (gpu_halted && !first_run)  state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // state register plus the load datapath, run counter and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            first_run  <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            prog_len   <= '0;
            run_cycles <= '0;
        end else begin
            state   <= state_nxt;
            imem_we <= 1'b0;

            if (enter_load) begin
                wr_ptr <= '0;
                if (state == S_IDLE) begin
                    prog_len <= '0;
                    err      <= 1'b0;
                end
            end

            if (state == S_IDLE && run_start && !load_start && !abort) begin
                err <= 1'b1;
            end

            if (accept) begin
                imem_we   <= 1'b1;
                imem_addr <= wr_ptr[ADDR_W-1:0];
                imem_data <= load_data;
                wr_ptr    <= wr_ptr + PTR_ONE;
                if (load_end) begin
                    prog_len <= wr_ptr + PTR_ONE;
                end
            end

            if (enter_run) begin
                run_cycles <= '0;
                timeout    <= 1'b0;
                first_run  <= 1'b1;
            end else if (state == S_RUN && !abort) begin
                first_run <= 1'b0;
                if (wd_expired) begin
                    timeout <= 1'b1;
                end else begin
                    run_cycles <= run_cycles + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_prog_ctrl.sv
// tb_gpu_prog_ctrl: scenario tasks against a queue-based reference of what
// the host stream should produce in instruction memory and run counters.
module tb_gpu_prog_ctrl;

    localparam int          ADDR_W  = 7;
    localparam int          DEPTH   = 128;
    localparam logic [31:0] TMO     = 32'd50;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [31:0]       load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              run_start = 1'b0;
    logic              abort = 1'b0;
    logic              gpu_halted = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              gpu_rst;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              err;
    logic [ADDR_W:0]   prog_len;
    logic [31:0]       run_cycles;

    int checks = 0;
    int fails  = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                exp_addr[$];
    logic [31:0]       exp_data[$];

    gpu_prog_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .run_start(run_start), .abort(abort), .gpu_halted(gpu_halted),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .gpu_rst(gpu_rst), .busy(busy), .done(done), .timeout(timeout), .err(err),
        .prog_len(prog_len), .run_cycles(run_cycles)
    );

    // free-running clock
    always #5 clk = ~clk;

    // record every instruction-memory write the DUT performs
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({gpu_rst, imem_we, load_ready, busy, done, timeout, err} !== 7'b1000000) begin
            fails++;
            $display("[TB] FAIL reset_flags got=%b exp=%b",
                     {gpu_rst, imem_we, load_ready, busy, done, timeout, err}, 7'b1000000);
        end
        checks++;
        if (imem_addr !== '0 || imem_data !== '0) begin
            fails++;
            $display("[TB] FAIL reset_imem addr=%0h data=%0h exp 0/0", imem_addr, imem_data);
        end
        checks++;
        if (prog_len !== '0 || run_cycles !== '0) begin
            fails++;
            $display("[TB] FAIL reset_counts prog_len=%0d run_cycles=%0d exp 0/0", prog_len, run_cycles);
        end
    endtask

    task automatic test_run_without_program();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        repeat (3) tick();
        checks++;
        if (err !== 1'b1 || gpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_no_program err=%b gpu_rst=%b busy=%b done=%b exp 1/1/0/0",
                     err, gpu_rst, busy, done);
        end
        pulse_load_start();
        checks++;
        if (err !== 1'b0 || load_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_cleared_by_load err=%b load_ready=%b exp 0/1", err, load_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_idle busy=%b load_ready=%b exp 0/0", busy, load_ready);
        end
    endtask

    task automatic test_basic_load_run();
        clear_logs();
        pulse_load_start();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h1000_0001 + 32'(i);
            load_last  = (i == 4);
            exp_addr.push_back(i);
            exp_data.push_back(load_data);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        checks++;
        if (got_addr.size() != 5) begin
            fails++;
            $display("[TB] FAIL basic_write_count got=%0d exp=5", got_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    fails++;
                    $display("[TB] FAIL basic_write[%0d] got=%0d:%h exp=%0d:%h",
                             i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (prog_len !== 8'd5 || load_ready !== 1'b0 || busy !== 1'b0 || gpu_rst !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_ready prog_len=%0d ready=%b busy=%b gpu_rst=%b exp 5/0/0/1",
                     prog_len, load_ready, busy, gpu_rst);
        end
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        checks++;
        if (gpu_rst !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_release gpu_rst=%b busy=%b exp 0/1", gpu_rst, busy);
        end
        repeat (20) tick();
        gpu_halted = 1'b1;
        tick();
        gpu_halted = 1'b0;
        checks++;
        if (done !== 1'b1 || gpu_rst !== 1'b1 || run_cycles !== 32'd21) begin
            fails++;
            $display("[TB] FAIL basic_halt done=%b gpu_rst=%b run_cycles=%0d exp 1/1/21",
                     done, gpu_rst, run_cycles);
        end
        repeat (3) tick();
        checks++;
        if (run_cycles !== 32'd21 || done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_hold run_cycles=%0d done=%b exp 21/1", run_cycles, done);
        end
    endtask

    task automatic test_rerun_stale_halt();
        for (int it = 0; it < 3; it++) begin
            int h;
            h = int'($urandom_range(1, 40));
            gpu_halted = 1'b1;
            run_start  = 1'b1;
            tick();
            run_start = 1'b0;
            tick();
            checks++;
            if (gpu_rst !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stale_halt_ignored gpu_rst=%b exp 0", gpu_rst);
            end
            gpu_halted = 1'b0;
            repeat (h - 1) tick();
            gpu_halted = 1'b1;
            tick();
            gpu_halted = 1'b0;
            checks++;
            if (done !== 1'b1 || timeout !== 1'b0 || run_cycles !== 32'(h + 1)) begin
                fails++;
                $display("[TB] FAIL rerun done=%b timeout=%b run_cycles=%0d exp 1/0/%0d",
                         done, timeout, run_cycles, h + 1);
            end
        end
    endtask

    task automatic test_full_load();
        int model_count;
        clear_logs();
        model_count = 0;
        pulse_load_start();
        for (int c = 0; c < 130; c++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            if (c == 127 || c == 128) begin
                checks++;
                if (load_ready !== (c == 127)) begin
                    fails++;
                    $display("[TB] FAIL full_ready_edge cycle=%0d got=%b exp=%b", c, load_ready, c == 127);
                end
            end
            if (model_count < DEPTH) begin
                exp_addr.push_back(model_count);
                exp_data.push_back(load_data);
                model_count++;
            end
            tick();
        end
        load_valid = 1'b0;
        tick();
        checks++;
        if (got_addr.size() != DEPTH) begin
            fails++;
            $display("[TB] FAIL full_write_count got=%0d exp=%0d", got_addr.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    fails++;
                    $display("[TB] FAIL full_write[%0d] got=%0d:%h exp=%0d:%h",
                             i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (prog_len !== 8'd128 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_ready prog_len=%0d busy=%b done=%b ready=%b exp 128/0/0/0",
                     prog_len, busy, done, load_ready);
        end
    endtask

    task automatic test_timeout();
        int n;
        gpu_halted = 1'b0;
        run_start  = 1'b1;
        tick();
        run_start = 1'b0;
        n = 0;
        while (gpu_rst === 1'b0 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != int'(TMO) + 1) begin
            fails++;
            $display("[TB] FAIL timeout_run_length got=%0d exp=%0d", n, int'(TMO) + 1);
        end
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1 || gpu_rst !== 1'b1 || run_cycles !== TMO) begin
            fails++;
            $display("[TB] FAIL timeout_flags timeout=%b done=%b gpu_rst=%b run_cycles=%0d exp 1/1/1/%0d",
                     timeout, done, gpu_rst, run_cycles, TMO);
        end
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick();
        checks++;
        if (timeout !== 1'b0 || gpu_rst !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rerun_clears_timeout timeout=%b gpu_rst=%b exp 0/0", timeout, gpu_rst);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (gpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_run gpu_rst=%b busy=%b done=%b exp 1/0/0", gpu_rst, busy, done);
        end
    endtask

    task automatic test_abort_mid_load();
        clear_logs();
        pulse_load_start();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            exp_addr.push_back(i);
            exp_data.push_back(load_data);
            tick();
        end
        load_valid = 1'b0;
        abort      = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (got_addr.size() != 3) begin
            fails++;
            $display("[TB] FAIL abort_write_count got=%0d exp=3", got_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    fails++;
                    $display("[TB] FAIL abort_write[%0d] got=%0d:%h exp=%0d:%h",
                             i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        got_addr.delete();
        got_data.delete();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        repeat (4) tick();
        checks++;
        if (err !== 1'b1 || prog_len !== '0 || gpu_rst !== 1'b1 || busy !== 1'b0 || got_addr.size() != 0) begin
            fails++;
            $display("[TB] FAIL abort_then_run err=%b prog_len=%0d gpu_rst=%b busy=%b writes=%0d exp 1/0/1/0/0",
                     err, prog_len, gpu_rst, busy, got_addr.size());
        end
    endtask

    task automatic test_toggle_restart();
        int ptr;
        int restart_at;
        clear_logs();
        ptr        = 0;
        restart_at = 2 * int'($urandom_range(3, 8)) + 1;
        pulse_load_start();
        for (int c = 0; c < 30; c++) begin
            load_valid = (c % 2 == 0);
            load_data  = $urandom;
            load_start = (c == restart_at);
            if (c == restart_at) begin
                ptr = 0;
            end else if (load_valid) begin
                exp_addr.push_back(ptr);
                exp_data.push_back(load_data);
                ptr++;
            end
            tick();
        end
        load_start = 1'b0;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = $urandom;
        exp_addr.push_back(ptr);
        exp_data.push_back(load_data);
        ptr++;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            fails++;
            $display("[TB] FAIL toggle_write_count got=%0d exp=%0d", got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    fails++;
                    $display("[TB] FAIL toggle_write[%0d] got=%0d:%h exp=%0d:%h",
                             i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (prog_len !== 8'(ptr) || busy !== 1'b0 || load_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL toggle_prog_len prog_len=%0d busy=%b ready=%b exp %0d/0/0",
                     prog_len, busy, load_ready, ptr);
        end
    endtask

    // run every scenario in order, then report
    initial begin
        test_reset();
        test_run_without_program();
        test_basic_load_run();
        test_rerun_stale_halt();
        test_full_load();
        test_timeout();
        test_abort_mid_load();
        test_toggle_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gpu_prog_ctrl.md
# gpu_prog_ctrl

Program loader and run sequencer for the GPU core. It accepts a streamed program from the host, writes it word by word into the 128 x 32 instruction memory's host write port while the GPU is held in reset, and releases the GPU on command. It then watches for HALT or a watchdog timeout and re-asserts GPU reset, reporting the program length and run-cycle count. It sits between the host register interface and the instruction memory / GPU core reset.

## Interface
- ADDR_W, 7: instruction memory address width.
- DEPTH, 128: instruction memory depth in words; equals 2^ADDR_W.
- TIMEOUT, 32'd1_000_000: maximum run cycles before forced stop.

- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  pulse: begin a new program load at address 0.
- load_valid  in  1  host word valid.
- load_data  in  32  host instruction word.
- load_last  in  1  qualifies load_valid; marks the final program word.
- load_ready  out  1  controller accepts a word this cycle.
- run_start  in  1  pulse: release the GPU to execute the loaded program.
- abort  in  1  pulse: stop any activity and return to IDLE.
- gpu_halted  in  1  level from the GPU core; high once HALT has executed.
- imem_we  out  1  to instruction memory host write enable.
- imem_addr  out  ADDR_W  to instruction memory host write address.
- imem_data  out  32  to instruction memory host write data.
- gpu_rst  out  1  GPU core reset; active-high.
- busy  out  1  high in LOAD or RUN.
- done  out  1  high in DONE.
- timeout  out  1  sticky; last run ended by the watchdog.
- err  out  1  sticky; run_start was issued with no program loaded.
- prog_len  out  ADDR_W+1  number of words in the last completed load, 0..128.
- run_cycles  out  32  cycles spent in RUN during the last or current run.

## Operation
- States: IDLE, LOAD, READY, RUN, DONE.
- IDLE: gpu_rst=1, load_ready=0.
  - load_start goes to LOAD and clears the write pointer, prog_len and err.
  - run_start sets err and stays in IDLE.
- LOAD: gpu_rst=1, load_ready=1.
  - A handshake (load_valid & load_ready) writes load_data at the write pointer, then increments the pointer.
  - Load ends on an accepted word with load_last=1, or on acceptance of the word at address DEPTH-1, even without load_last.
  - At load end: prog_len = number of words accepted, then go to READY.
  - load_start while in LOAD restarts the load at address 0.
- READY: gpu_rst=1.
  - run_start goes to RUN and clears run_cycles and timeout.
  - load_start goes to LOAD.
- RUN: gpu_rst=0, and run_cycles increments every RUN cycle.
  - gpu_halted=1 goes to DONE.
  - run_cycles reaching TIMEOUT sets timeout and goes to DONE.
  - run_start and load_start are ignored.
- DONE: gpu_rst=1; run_cycles is held.
  - run_start reruns the same program (goes to RUN).
  - load_start goes to LOAD.
- abort in any state goes to IDLE with gpu_rst=1. Instruction memory contents are untouched; prog_len is kept.
- Priority: reset > abort > load_start > run_start > gpu_halted/timeout.
- Instruction memory words beyond prog_len are not written; they keep their previous contents.

## Timing
- Reset values:
  - state IDLE, gpu_rst=1.
  - imem_we=0, imem_addr=0, imem_data=0.
  - load_ready=0, busy=0, done=0, timeout=0, err=0.
  - prog_len=0, run_cycles=0.
- Write latency: a handshake in cycle N gives imem_we=1 in cycle N+1, with the registered address and data. There is at most one write per cycle, and back-to-back writes are supported.
- load_ready is a registered function of state. It is 1 starting the cycle after load_start is sampled. It drops in the cycle after the final word is accepted.
- run_start sampled in cycle N: gpu_rst=0 from cycle N+1. The final load write (cycle N_last+1) always completes before the earliest possible release.
- gpu_halted sampled high in cycle M: state is DONE and gpu_rst=1 in cycle M+1. run_cycles counts RUN cycles through M inclusive.
- Watchdog: run_cycles is compared against TIMEOUT before incrementing. The run exits the cycle after run_cycles == TIMEOUT.
- gpu_halted is ignored outside RUN, including a stale high level during the first RUN cycle's reset release.

## Test plan
- Load 5 words (0x1000_0001..0x1000_0005, last on word 5), then run_start; hold gpu_halted=0 for 20 cycles, then 1 -> required:
  - imem writes to addresses 0..4 in order;
  - prog_len=5;
  - done=1 one cycle after gpu_halted;
  - run_cycles=21, gpu_rst=1.
- Stream 130 words with load_valid held high and load_last never asserted -> required:
  - exactly 128 writes (addresses 0..127);
  - load_ready=0 after the 128th acceptance;
  - prog_len=128; state READY.
- run_start straight out of reset -> required: err=1, gpu_rst stays 1, state IDLE; a subsequent load clears err.
- TIMEOUT=50, gpu_halted held 0 -> required: timeout=1, done=1, gpu_rst=1 after 51 RUN cycles; run_cycles=50.
- abort mid-load after 3 words, then run_start -> required:
  - IDLE;
  - no further imem_we;
  - err=1 (prog_len still 0, since the interrupted load never completed).
- load_valid toggled 1/0 every cycle during load, plus load_start asserted mid-load -> required:
  - only handshaken words are written;
  - pointer restarts at 0 after load_start.
